// File: rtl/somador_4b_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master side supplies the operands; the slave side (the adder) returns the
// registered sum and its status flags.
interface somador_4b_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             out_valid;

    modport master (
        output in_valid, a, b, cin,
        input  s, cout, ovf, zero, out_valid
    );

    modport slave (
        input  in_valid, a, b, cin,
        output s, cout, ovf, zero, out_valid
    );
endinterface

// File: rtl/somador_4b.sv
// Registered ripple-carry adder: {cout, s} = a + b + cin with signed-overflow
// and zero flags. Every output comes from a flop, so there is exactly one cycle
// of latency and no combinational path from the operands to the outputs.
// The interface instance must be built with the same WIDTH as this module.
module somador_4b #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    somador_4b_if.slave   bus
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_nxt;
    logic             ovf_nxt;
    logic             zero_nxt;

    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             out_valid_q;

    // Ripple chain of WIDTH full adders plus the flags derived from that same sum.
    always_comb begin
        carry    = '0;
        sum_nxt  = '0;
        carry[0] = bus.cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum_nxt[i]   = bus.a[i] ^ bus.b[i] ^ carry[i];
            carry[i+1]   = (bus.a[i] & bus.b[i]) | (carry[i] & (bus.a[i] ^ bus.b[i]));
        end
        // Signed overflow: carry into the MSB differs from carry out of it.
        ovf_nxt  = carry[WIDTH] ^ carry[WIDTH-1];
        zero_nxt = (sum_nxt == '0);
    end

    // Result registers: reset wins, results load on in_valid, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s_q    <= sum_nxt;
                cout_q <= carry[WIDTH];
                ovf_q  <= ovf_nxt;
                zero_q <= zero_nxt;
            end
        end
    end

    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_somador_4b.sv
// Directed bench for somador_4b: reset behaviour, hand-computed vectors,
// hold/back-to-back behaviour and an exhaustive sweep against a reference sum.
module tb_somador_4b;

    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    somador_4b_if #(.WIDTH(WIDTH)) bus ();

    somador_4b #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] es, input logic ec,
                           input logic eo, input logic ez, input logic ev);
        chk({tag, ".s"},         32'(bus.s),         32'(es));
        chk({tag, ".cout"},      32'(bus.cout),      32'(ec));
        chk({tag, ".ovf"},       32'(bus.ovf),       32'(eo));
        chk({tag, ".zero"},      32'(bus.zero),      32'(ez));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
    endtask

    // Drive one cycle of stimulus at the falling edge, then sample just after the rising edge.
    task automatic step(input logic r, input logic iv, input logic [3:0] aa,
                        input logic [3:0] bb, input logic cc);
        @(negedge clk);
        rst          = r;
        bus.in_valid = iv;
        bus.a        = aa;
        bus.b        = bb;
        bus.cin      = cc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] ref_sum;
        logic [3:0] es;
        logic       eo;
        n_vec = 0;
        n_err = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.cin      = 1'b0;

        // Reset for two cycles with live-looking operands.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
            chk_out("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        step(1'b0, 1'b1, 4'b0010, 4'b0110, 1'b0);
        chk_out("2+6", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);

        step(1'b0, 1'b1, 4'b1100, 4'b0100, 1'b0);
        chk_out("12+4", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);

        step(1'b0, 1'b1, 4'b0011, 4'b0110, 1'b0);
        chk_out("3+6", 4'b1001, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'b0011, 4'b0110, 1'b1);
        chk_out("3+6+1", 4'b1010, 1'b0, 1'b1, 1'b0, 1'b1);

        step(1'b0, 1'b1, 4'b1111, 4'b1111, 1'b1);
        chk_out("f+f+1", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 4'b0001, 4'b0010, 1'b0);
            chk_out("hold", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        step(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0);
        chk_out("f+1", 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);

        step(1'b0, 1'b1, 4'b0111, 4'b0001, 1'b0);
        chk_out("7+1", 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1);

        step(1'b1, 1'b1, 4'b0101, 4'b0101, 1'b0);
        chk_out("rst_mid", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'b0101, 4'b0101, 1'b0);
        chk_out("rst_after", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Exhaustive sweep, back-to-back, each result checked one cycle after sampling.
        for (int i = 0; i < 512; i++) begin
            logic [3:0] va;
            logic [3:0] vb;
            logic       vc;
            va      = 4'(i >> 5);
            vb      = 4'(i >> 1);
            vc      = 1'(i);
            ref_sum = 5'(va) + 5'(vb) + 5'(vc);
            es      = ref_sum[3:0];
            eo      = (va[3] == vb[3]) && (es[3] != va[3]);
            step(1'b0, 1'b1, va, vb, vc);
            chk_out($sformatf("sweep%0d", i), es, ref_sum[4], eo, (es == 4'h0), 1'b1);
        end

        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        chk_out("tail", 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
